// File: rtl/rv32_mem_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, the access FSM
// state and error-cause encodings, and decode helpers used by the
// load/store unit.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10,
        FAULT  = 2'b11
    } mau_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_FUNCT3   = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } mau_err_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else
            return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                   (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // funct3[1:0] gives the access size for every legal encoding:
    // 00 byte, 01 half, 10 word.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data formatter: selects the addressed byte/half of a memory word and
// sign- or zero-extends it according to the RV32I load funct3.
//   rdata_i   in  32  raw memory word
//   offset_i  in  2   byte offset within the word (addr[1:0])
//   funct3_i  in  3   load funct3
//   data_o    out 32  formatted writeback value
module load_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store unit: performs one byte/half/word access per start
// request over a word-wide req/ready memory port, formats load data,
// steers store byte lanes and reports misaligned / illegal / timeout errors.
//   clk, rst_n                       clock, async active-low reset
//   start_i, is_store_i, funct3_i,
//   addr_i, store_data_i             request, sampled in IDLE
//   busy_o, done_o, err_o, err_cause_o  status to the controller
//   load_data_o                      last successful load result
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wmask_o, mem_wdata_o         memory request
//   mem_rdata_i, mem_ready_i         memory response
//
// state  | meaning
// IDLE   | waiting for start_i; decodes and captures the request
// ACCESS | mem_req_o high until mem_ready_i or timeout
// DONE   | one-cycle success pulse
// FAULT  | one-cycle error pulse, no memory access performed/completed
module mem_access_unit
    import rv32_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o,
    output logic [31:0] load_data_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mau_state_t  state_q, state_d;
    mau_err_t    err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] load_q, load_d;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic        capture;
    logic [31:0] aligned;
    logic [3:0]  wmask_raw;

    load_align u_load_align (
        .rdata_i  (mem_rdata_i),
        .offset_i (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (aligned)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    capture = 1'b1;
                    if (!f3_legal(is_store_i, funct3_i)) begin
                        state_d = FAULT;
                        err_d   = ERR_FUNCT3;
                    end else if (misaligned(funct3_i, addr_i[1:0])) begin
                        state_d = FAULT;
                        err_d   = ERR_MISALIGN;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready_i) begin
                    state_d = DONE;
                    if (!is_store_q) load_d = aligned;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FAULT;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            err_q      <= ERR_NONE;
            cnt_q      <= '0;
            load_q     <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            if (capture) begin
                is_store_q <= is_store_i;
                funct3_q   <= funct3_i;
                addr_q     <= addr_i;
                sdata_q    <= store_data_i;
            end
        end
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                wmask_raw   = 4'b0001 << addr_q[1:0];
                mem_wdata_o = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                wmask_raw   = 4'b0011 << addr_q[1:0];
                mem_wdata_o = {2{sdata_q[15:0]}};
            end
            default: begin
                wmask_raw   = 4'b1111;
                mem_wdata_o = sdata_q;
            end
        endcase
    end

    assign mem_req_o   = (state_q == ACCESS);
    assign mem_we_o    = mem_req_o & is_store_q;
    assign mem_wmask_o = mem_we_o ? wmask_raw : 4'b0000;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE) || (state_q == FAULT);
    assign err_o       = (state_q == FAULT);
    assign err_cause_o = (state_q == FAULT) ? err_q : ERR_NONE;
    assign load_data_o = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_cause_o;
    logic [31:0] load_data_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_cause_o  (err_cause_o),
        .load_data_o  (load_data_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i)
    );

    // Called at a negedge; returns at the next negedge (one cycle after start).
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        start_i      = 1'b1;
        is_store_i   = st;
        funct3_i     = f3;
        addr_i       = a;
        store_data_i = d;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Zero-wait response from the ACCESS negedge; returns at the DONE negedge.
    task automatic respond_now(input logic [31:0] rd);
        mem_ready_i = 1'b1;
        mem_rdata_i = rd;
        @(negedge clk);
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h0;
    endtask

    task automatic test_reset;
        checks++;
        if ({busy_o, done_o, err_o, err_cause_o, mem_req_o, mem_we_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b done=%b err=%b cause=%b req=%b we=%b, want all 0",
                     busy_o, done_o, err_o, err_cause_o, mem_req_o, mem_we_o);
        end
        checks++;
        if (load_data_o !== 32'h0 || mem_wmask_o !== 4'h0 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got load=%h wmask=%b addr=%h, want 0",
                     load_data_o, mem_wmask_o, mem_addr_o);
        end
    endtask

    task automatic test_load_byte;
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h100 || mem_wmask_o !== 4'b0000) begin
            errors++;
            $display("FAIL lb_request: got req=%b we=%b addr=%h wmask=%b, want 1 0 00000100 0000",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o);
        end
        respond_now(32'h80FF_1234);
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || err_cause_o !== 2'b00 || load_data_o !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_done: got done=%b err=%b cause=%b load=%h, want 1 0 00 ffffff80",
                     done_o, err_o, err_cause_o, load_data_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL lb_idle: got busy=%b done=%b, want 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_load_half;
        issue(1'b0, 3'b101, 32'h0000_0102, 32'h0);
        respond_now(32'h8001_0000);
        checks++;
        if (done_o !== 1'b1 || load_data_o !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu: got done=%b load=%h, want 1 00008001", done_o, load_data_o);
        end
        @(negedge clk);
        issue(1'b0, 3'b001, 32'h0000_0102, 32'h0);
        respond_now(32'h8001_0000);
        checks++;
        if (done_o !== 1'b1 || load_data_o !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh: got done=%b load=%h, want 1 ffff8001", done_o, load_data_o);
        end
        @(negedge clk);
    endtask

    task automatic test_store;
        issue(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB);
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h200 ||
            mem_wmask_o !== 4'b0010 || mem_wdata_o !== 32'hABAB_ABAB) begin
            errors++;
            $display("FAIL sb_request: got req=%b we=%b addr=%h wmask=%b wdata=%h, want 1 1 00000200 0010 abababab",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o);
        end
        respond_now(32'h0);
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || load_data_o !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL sb_done: got done=%b err=%b load=%h, want 1 0 ffff8001", done_o, err_o, load_data_o);
        end
        @(negedge clk);
        issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_56AB);
        checks++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_wmask_o !== 4'b1100 || mem_wdata_o !== 32'h56AB_56AB) begin
            errors++;
            $display("FAIL sh_request: got we=%b addr=%h wmask=%b wdata=%h, want 1 00000200 1100 56ab56ab",
                     mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o);
        end
        respond_now(32'h0);
        @(negedge clk);
        issue(1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D);
        checks++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h204 || mem_wmask_o !== 4'b1111 || mem_wdata_o !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL sw_request: got we=%b addr=%h wmask=%b wdata=%h, want 1 00000204 1111 cafef00d",
                     mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o);
        end
        respond_now(32'h0);
        @(negedge clk);
    endtask

    task automatic test_wait_states;
        int cyc;
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        cyc = 1;
        mem_ready_i = 1'b0;
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk); cyc++;
        mem_ready_i = 1'b0;
        while (!done_o && cyc < 10) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (cyc !== 4 || load_data_o !== 32'hDEAD_BEEF || err_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_wait: got latency=%0d load=%h err=%b, want 4 deadbeef 0", cyc, load_data_o, err_o);
        end
        @(negedge clk);
    endtask

    task automatic test_faults;
        issue(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b1 || err_cause_o !== 2'b01 || mem_req_o !== 1'b0 ||
            load_data_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lw_misalign: got done=%b err=%b cause=%b req=%b load=%h, want 1 1 01 0 deadbeef",
                     done_o, err_o, err_cause_o, mem_req_o, load_data_o);
        end
        @(negedge clk);
        issue(1'b0, 3'b101, 32'h0000_0103, 32'h0);
        checks++;
        if (err_o !== 1'b1 || err_cause_o !== 2'b01 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL lhu_misalign: got err=%b cause=%b req=%b, want 1 01 0", err_o, err_cause_o, mem_req_o);
        end
        @(negedge clk);
        issue(1'b1, 3'b011, 32'h0000_0200, 32'h0);
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b1 || err_cause_o !== 2'b10 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL sb_funct3: got done=%b err=%b cause=%b we=%b, want 1 1 10 0",
                     done_o, err_o, err_cause_o, mem_we_o);
        end
        @(negedge clk);
        // Store with a load-only encoding and misaligned address: funct3 wins.
        issue(1'b1, 3'b100, 32'h0000_0203, 32'h0);
        checks++;
        if (err_cause_o !== 2'b10 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL store_f3_100: got cause=%b req=%b, want 10 0", err_cause_o, mem_req_o);
        end
        @(negedge clk);
        issue(1'b0, 3'b011, 32'h0000_0200, 32'h0);
        checks++;
        if (err_cause_o !== 2'b10 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL load_f3_011: got err=%b cause=%b, want 1 10", err_o, err_cause_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL fault_idle: got busy=%b done=%b, want 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_timeout;
        int  req_cycles;
        logic seen, we_seen;
        logic [1:0] cause;
        req_cycles = 0;
        seen = 1'b0;
        we_seen = 1'b0;
        cause = 2'b00;
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (mem_req_o) req_cycles++;
            if (mem_we_o) we_seen = 1'b1;
            if (done_o) begin
                seen = 1'b1;
                cause = err_cause_o;
                break;
            end
            if (i == 3) begin
                start_i = 1'b1;
                is_store_i = 1'b1;
                funct3_i = 3'b010;
                addr_i = 32'h0000_0600;
                store_data_i = 32'h1111_2222;
            end
            if (i == 4) start_i = 1'b0;
            @(negedge clk);
        end
        start_i = 1'b0;
        checks++;
        if (!seen || cause !== 2'b11 || req_cycles != 16) begin
            errors++;
            $display("FAIL timeout: got done_seen=%b cause=%b req_cycles=%0d, want 1 11 16", seen, cause, req_cycles);
        end
        checks++;
        if (we_seen !== 1'b0 || load_data_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL timeout_side: got we_seen=%b load=%h, want 0 deadbeef", we_seen, load_data_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start: got busy=%b req=%b after fault, want 0 0", busy_o, mem_req_o);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_req: got req=%b, want 1", mem_req_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || load_data_o !== 32'h0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got req=%b busy=%b load=%h done=%b, want 0 0 0 0",
                     mem_req_o, busy_o, load_data_o, done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 3'b010, 32'h0000_0504, 32'h0);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h504) begin
            errors++;
            $display("FAIL post_reset_req: got req=%b addr=%h, want 1 00000504", mem_req_o, mem_addr_o);
        end
        respond_now(32'h0102_0304);
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || load_data_o !== 32'h0102_0304) begin
            errors++;
            $display("FAIL post_reset_lw: got done=%b err=%b load=%h, want 1 0 01020304",
                     done_o, err_o, load_data_o);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        start_i      = 1'b0;
        is_store_i   = 1'b0;
        funct3_i     = 3'b000;
        addr_i       = 32'h0;
        store_data_i = 32'h0;
        mem_rdata_i  = 32'h0;
        mem_ready_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_load_byte();
        test_load_half();
        test_store();
        test_wait_states();
        test_faults();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
